// File: rtl/gfx_pkg.sv
// Shared constants and types for the VGA object renderer graphics blocks.
// Holds tile geometry, colour format and the built-in bitmap pattern.
package gfx_pkg;

    localparam int TILE_DIM  = 16;
    localparam int TILE_BITS = 4;
    localparam int NUM_TILES = 16;
    localparam int COLOR_W   = 6;
    localparam int ROM_AW    = 12;

    typedef logic [5:0] rgb_t;

    // Tile number lands in bits 5:2 so a tile's identity is visible on screen
    function automatic rgb_t builtin_pixel(input logic [ROM_AW-1:0] word);
        return {word[11:8], word[4] ^ word[0], word[0]};
    endfunction

endpackage

// File: rtl/bitmap_rom.sv
// Synchronous read-only bitmap store: 12-bit word address in, colour out one
// clock later. Contents come from the built-in pattern.
module bitmap_rom
    import gfx_pkg::*;
#(
    parameter INIT_FILE = "",
    parameter int DATA_W = COLOR_W
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [DATA_W-1:0] data
);

    generate
        if (INIT_FILE == "") begin : g_builtin
            always_ff @(posedge clk) begin
                data <= DATA_W'(builtin_pixel(addr));
            end
        end else begin : g_file
            logic [DATA_W-1:0] mem [0:(1<<ROM_AW)-1];

            // Memory initialisation; infers an initialised block ROM
            initial begin
                for (int i = 0; i < (1 << ROM_AW); i++) begin
                    mem[i] = DATA_W'(builtin_pixel(ROM_AW'(i)));
                end
            end

            always_ff @(posedge clk) begin
                data <= mem[addr];
            end
        end
    endgenerate

endmodule

// File: rtl/bitmap_bank.sv
// Sprite bitmap bank: maps object base tile, width and pixel offset onto a
// ROM word and returns that pixel's colour one clock later.
module bitmap_bank
    import gfx_pkg::*;
#(
    parameter INIT_FILE = "bitmaps.hex",
    parameter int COLOR_W = gfx_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         addr,
    input  logic               width,
    input  logic [4:0]         hpos,
    input  logic [4:0]         vpos,
    output logic [COLOR_W-1:0] pixel
);

    logic [TILE_BITS-1:0] tile_offset;
    logic [TILE_BITS-1:0] tile;
    logic [ROM_AW-1:0]    word;
    logic [COLOR_W-1:0]   rom_data;
    logic                 data_valid;

    // Wide objects are a 2x2 tile block in row-major order; narrow ones stack two tiles
    always_comb begin
        tile_offset = '0;
        if (width) begin
            tile_offset = {2'b00, vpos[4], hpos[4]};
        end else begin
            tile_offset = {3'b000, vpos[4]};
        end
        tile = addr + tile_offset;
        word = {tile, vpos[3:0], hpos[3:0]};
    end

    bitmap_rom #(
        .INIT_FILE (INIT_FILE),
        .DATA_W    (COLOR_W)
    ) u_rom (
        .clk  (clk),
        .addr (word),
        .data (rom_data)
    );

    // ROM register has no reset (block-RAM friendly); this flag blanks it
    // asynchronously and re-opens on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b1;
        end
    end

    assign pixel = data_valid ? rom_data : '0;

endmodule

// File: tb/tb_bitmap_bank.sv
// Self-checking bench for bitmap_bank using the built-in bitmap pattern.
// Expected colours are queued when inputs are driven and checked after the edge.
module tb_bitmap_bank;

    typedef struct {
        string      tag;
        logic [5:0] expected;
    } sb_entry_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] addr;
    logic       width;
    logic [4:0] hpos;
    logic [4:0] vpos;
    logic [5:0] pixel;

    int n_checks = 0;
    int n_fails  = 0;
    sb_entry_t sb_queue[$];

    bitmap_bank #(
        .INIT_FILE (""),
        .COLOR_W   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .width (width),
        .hpos  (hpos),
        .vpos  (vpos),
        .pixel (pixel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] model_pixel(input logic [3:0] a, input logic w,
                                               input logic [4:0] h, input logic [4:0] v);
        int         t;
        logic [3:0] tile;
        logic [11:0] wd;
        if (w) t = int'(a) + 2 * int'(v[4]) + int'(h[4]);
        else   t = int'(a) + int'(v[4]);
        tile = 4'(t % 16);
        wd = {tile, v[3:0], h[3:0]};
        return {wd[11:8], wd[4] ^ wd[0], wd[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] observed,
                               input logic [5:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic setInputs(input string tag, input logic [3:0] a, input logic w,
                             input logic [4:0] h, input logic [4:0] v);
        sb_entry_t e;
        addr  = a;
        width = w;
        hpos  = h;
        vpos  = v;
        e.tag = tag;
        e.expected = model_pixel(a, w, h, v);
        sb_queue.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] a, input logic w,
                                 input logic [4:0] h, input logic [4:0] v);
        @(negedge clk);
        setInputs(tag, a, w, h, v);
    endtask

    // Same as applyStimulus but with a spec-given constant cross-checking the model
    task automatic applyKnown(input string tag, input logic [3:0] a, input logic w,
                              input logic [4:0] h, input logic [4:0] v,
                              input logic [5:0] known);
        sb_entry_t e;
        @(negedge clk);
        addr  = a;
        width = w;
        hpos  = h;
        vpos  = v;
        e.tag = tag;
        e.expected = known;
        sb_queue.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst_n && sb_queue.size() > 0) begin
            sb_entry_t e;
            e = sb_queue.pop_front();
            #1;
            checkOutput(e.tag, pixel, e.expected);
        end
    end

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        width = 1'b0;
        hpos  = '0;
        vpos  = '0;
        #2;
        checkOutput("reset_initial", pixel, 6'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("tile_16x16", 4'd8, 1'b0, 5'd3, 5'd5);
        applyStimulus("tall_hpos_ignored", 4'd4, 1'b0, 5'd17, 5'd20);
        applyKnown("quad_0", 4'd0, 1'b1, 5'd0, 5'd0, 6'h00);
        applyKnown("quad_1", 4'd0, 1'b1, 5'd16, 5'd0, 6'h04);
        applyKnown("quad_2", 4'd0, 1'b1, 5'd0, 5'd16, 6'h08);
        applyStimulus("quad_3", 4'd0, 1'b1, 5'd31, 5'd31);
        applyKnown("wrap_tile", 4'd15, 1'b1, 5'd16, 5'd16, 6'b001000);
        applyStimulus("narrow_wrap", 4'd15, 1'b0, 5'd9, 5'd18);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("pipe_addr%0d", i), 4'(i), 1'b0, 5'd0, 5'd0);
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("random_%0d", i), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
        end

        // Mid-stream reset: load a non-zero pixel, then drop rst_n between edges
        applyStimulus("pre_reset", 4'd12, 1'b0, 5'd1, 5'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", pixel, 6'h00);
        sb_queue.delete();
        applyStimulus("held_in_reset", 4'd9, 1'b1, 5'd31, 5'd31);
        sb_queue.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", pixel, 6'h00);

        @(negedge clk);
        rst_n = 1'b1;
        setInputs("first_after_release", 4'd7, 1'b1, 5'd16, 5'd21);
        applyStimulus("second_after_release", 4'd3, 1'b0, 5'd2, 5'd30);

        for (int k = 0; k < 10 && sb_queue.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("scoreboard_drained", 6'(sb_queue.size()), 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
